// File: rtl/fifo_ctrl_prog.sv
// Pointer/count manager for a single-clock FIFO of arbitrary DEPTH, with programmable almost flags.
// Optional high-watermark register is built when FIFO_CTRL_WMARK_EN is defined.
module fifo_ctrl_prog #(
   parameter  int unsigned DEPTH   = 16,
   localparam int          PTR_WID = $clog2(DEPTH),
   localparam int          CNT_WID = PTR_WID + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               wen,
   input  logic               oen,
   input  logic [CNT_WID-1:0] afull_th,
   input  logic [CNT_WID-1:0] aempty_th,
   output logic [PTR_WID-1:0] rd_ptr,
   output logic [PTR_WID-1:0] wr_ptr,
   output logic [CNT_WID-1:0] count,
   output logic               full,
   output logic               empty,
   output logic               afull,
   output logic               aempty,
   output logic               ovf,
   output logic               udf,
   output logic [CNT_WID-1:0] wmark
);

   localparam logic [CNT_WID-1:0] DEPTH_CNT = CNT_WID'(DEPTH);
   localparam logic [31:0]        LAST_IDX  = 32'(DEPTH - 1);

   logic [CNT_WID-1:0] count_q, count_d;
   logic [PTR_WID-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_WID-1:0] wr_ptr_q, wr_ptr_d;
   logic               ovf_q, ovf_d;
   logic               udf_q, udf_d;
   logic               full_s, empty_s;
   logic               push_ok, pop_ok;

   // Wrap compare is done at 32 bits so non-power-of-two depths roll over at DEPTH-1.
   function automatic logic [PTR_WID-1:0] ptr_inc(input logic [PTR_WID-1:0] p);
      if (32'(p) == LAST_IDX) return '0;
      return p + PTR_WID'(1);
   endfunction

   assign full_s  = (count_q == DEPTH_CNT);
   assign empty_s = (count_q == '0);

   // A pop at full frees its slot in the same cycle, so the push is still accepted.
   assign pop_ok  = oen & ~empty_s;
   assign push_ok = wen & (~full_s | oen);

   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      if (clr) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
         if (push_ok & ~pop_ok)      count_d = count_q + CNT_WID'(1);
         else if (pop_ok & ~push_ok) count_d = count_q - CNT_WID'(1);
         if (wen & ~push_ok) ovf_d = 1'b1;
         if (oen & ~pop_ok)  udf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

`ifdef FIFO_CTRL_WMARK_EN
   logic [CNT_WID-1:0] wmark_q, wmark_d;

   // Tracks registered count, so the mark trails the count by one edge.
   always_comb begin
      wmark_d = wmark_q;
      if (clr)                     wmark_d = '0;
      else if (count_q > wmark_q)  wmark_d = count_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wmark_q <= '0;
      else        wmark_q <= wmark_d;
   end

   assign wmark = wmark_q;
`else
   assign wmark = '0;
`endif

   assign rd_ptr = rd_ptr_q;
   assign wr_ptr = wr_ptr_q;
   assign count  = count_q;
   assign full   = full_s;
   assign empty  = empty_s;
   assign afull  = (count_q >= afull_th);
   assign aempty = (count_q <= aempty_th);
   assign ovf    = ovf_q;
   assign udf    = udf_q;

endmodule

// File: tb/tb_fifo_ctrl_prog.sv
// Scoreboard bench: a DEPTH=16 and a DEPTH=5 controller share push/pop/flush stimulus,
// each checked every cycle against an occupancy model kept in plain integers.
module tb_fifo_ctrl_prog;

   logic clk = 1'b0;
   logic rst_n, clr, wen, oen;

   logic [4:0] at16, ae16, cnt16, wm16;
   logic [3:0] rd16, wr16;
   logic       full16, empty16, afull16, aempty16, ovf16, udf16;

   logic [3:0] at5, ae5, cnt5, wm5;
   logic [2:0] rd5, wr5;
   logic       full5, empty5, afull5, aempty5, ovf5, udf5;

   always #5 clk = ~clk;

   fifo_ctrl_prog #(.DEPTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wen(wen), .oen(oen),
      .afull_th(at16), .aempty_th(ae16), .rd_ptr(rd16), .wr_ptr(wr16),
      .count(cnt16), .full(full16), .empty(empty16), .afull(afull16),
      .aempty(aempty16), .ovf(ovf16), .udf(udf16), .wmark(wm16)
   );

   fifo_ctrl_prog #(.DEPTH(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wen(wen), .oen(oen),
      .afull_th(at5), .aempty_th(ae5), .rd_ptr(rd5), .wr_ptr(wr5),
      .count(cnt5), .full(full5), .empty(empty5), .afull(afull5),
      .aempty(aempty5), .ovf(ovf5), .udf(udf5), .wmark(wm5)
   );

`ifdef FIFO_CTRL_WMARK_EN
   localparam bit WM_EN = 1'b1;
`else
   localparam bit WM_EN = 1'b0;
`endif

   typedef struct {
      bit c, w, o;
      int cnt, rd, wr, wm;
      bit full, empty, afull, aempty, ovf, udf;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int n_chk = 0;
   int n_err = 0;
   int n_txn = 0;

   int dep[2]   = '{16, 5};
   int m_cnt[2] = '{0, 0};
   int m_rd[2]  = '{0, 0};
   int m_wr[2]  = '{0, 0};
   int m_wm[2]  = '{0, 0};
   bit m_ovf[2] = '{0, 0};
   bit m_udf[2] = '{0, 0};
   int at_n[2]  = '{16, 5};
   int ae_n[2]  = '{0, 0};

   function automatic void cmp(string nm, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic void model_clear();
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0; m_rd[k] = 0; m_wr[k] = 0;
         m_wm[k]  = 0; m_ovf[k] = 0; m_udf[k] = 0;
      end
   endfunction

   // Occupancy model: a pop is served first, and the push fits if room remains after it.
   function automatic void model_step(int k, bit c, bit w, bit o);
      exp_t e;
      bit   pok, wok;
      int   old;
      if (c) begin
         m_cnt[k] = 0; m_rd[k] = 0; m_wr[k] = 0;
         m_wm[k]  = 0; m_ovf[k] = 0; m_udf[k] = 0;
      end else begin
         old = m_cnt[k];
         pok = o && (old > 0);
         wok = w && ((old - int'(pok)) < dep[k]);
         if (w && !wok) m_ovf[k] = 1'b1;
         if (o && !pok) m_udf[k] = 1'b1;
         m_cnt[k] = old + int'(wok) - int'(pok);
         m_wr[k]  = (m_wr[k] + int'(wok)) % dep[k];
         m_rd[k]  = (m_rd[k] + int'(pok)) % dep[k];
         if (old > m_wm[k]) m_wm[k] = old;
      end
      e.c = c; e.w = w; e.o = o;
      e.cnt    = m_cnt[k];
      e.rd     = m_rd[k];
      e.wr     = m_wr[k];
      e.wm     = WM_EN ? m_wm[k] : 0;
      e.full   = (m_cnt[k] == dep[k]);
      e.empty  = (m_cnt[k] == 0);
      e.afull  = (m_cnt[k] >= at_n[k]);
      e.aempty = (m_cnt[k] <= ae_n[k]);
      e.ovf    = m_ovf[k];
      e.udf    = m_udf[k];
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
   endfunction

   task automatic drive(input bit c, input bit w, input bit o);
      @(negedge clk);
      clr = c; wen = w; oen = o;
      at16 = 5'(at_n[0]); ae16 = 5'(ae_n[0]);
      at5  = 4'(at_n[1]); ae5  = 4'(ae_n[1]);
      model_step(0, c, w, o);
      model_step(1, c, w, o);
   endtask

   function automatic void check_one(string tag, exp_t e, int cnt, int rd, int wr, int wm,
                                     bit f, bit em, bit af, bit ae, bit ov, bit ud);
      cmp({tag, ".count"},  cnt, e.cnt);
      cmp({tag, ".rd_ptr"}, rd,  e.rd);
      cmp({tag, ".wr_ptr"}, wr,  e.wr);
      cmp({tag, ".wmark"},  wm,  e.wm);
      cmp({tag, ".full"},   int'(f),  int'(e.full));
      cmp({tag, ".empty"},  int'(em), int'(e.empty));
      cmp({tag, ".afull"},  int'(af), int'(e.afull));
      cmp({tag, ".aempty"}, int'(ae), int'(e.aempty));
      cmp({tag, ".ovf"},    int'(ov), int'(e.ovf));
      cmp({tag, ".udf"},    int'(ud), int'(e.udf));
   endfunction

   // Monitor: after every rising edge, compare each DUT with its oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            check_one("d16", e, int'(cnt16), int'(rd16), int'(wr16), int'(wm16),
                      full16, empty16, afull16, aempty16, ovf16, udf16);
            n_txn++;
            $display("txn %0d clr=%b wen=%b oen=%b | d16 cnt=%0d rd=%0d wr=%0d | d5 cnt=%0d rd=%0d wr=%0d",
                     n_txn, e.c, e.w, e.o, cnt16, rd16, wr16, cnt5, rd5, wr5);
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            check_one("d5", e, int'(cnt5), int'(rd5), int'(wr5), int'(wm5),
                      full5, empty5, afull5, aempty5, ovf5, udf5);
         end
      end
   end

   initial begin
      rst_n = 1'b0; clr = 1'b0; wen = 1'b0; oen = 1'b0;
      at16 = '0; ae16 = '0; at5 = '0; ae5 = '0;
      repeat (2) @(posedge clk);
      #1;
      cmp("rst.d16.count", int'(cnt16), 0);
      cmp("rst.d16.rd_ptr", int'(rd16), 0);
      cmp("rst.d16.wr_ptr", int'(wr16), 0);
      cmp("rst.d16.empty", int'(empty16), 1);
      cmp("rst.d16.full", int'(full16), 0);
      cmp("rst.d16.aempty", int'(aempty16), 1);
      cmp("rst.d16.afull_th0", int'(afull16), 1);
      cmp("rst.d16.ovf", int'(ovf16), 0);
      cmp("rst.d16.udf", int'(udf16), 0);
      cmp("rst.d16.wmark", int'(wm16), 0);
      cmp("rst.d5.count", int'(cnt5), 0);
      cmp("rst.d5.afull_th0", int'(afull5), 1);
      at16 = 5'd5;
      #1;
      cmp("rst.d16.afull_th5", int'(afull16), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fill past full: ovf after the 17th push, wr_ptr back to 0.
      repeat (17) drive(0, 1, 0);
      // Simultaneous push/pop at full.
      repeat (3) drive(0, 1, 1);
      drive(1, 0, 0);
      // Alternating push/pop shows the DEPTH=5 wrap.
      repeat (7) begin
         drive(0, 1, 0);
         drive(0, 0, 1);
      end
      // Push/pop at empty: only the push is taken; then flush drops a push.
      drive(0, 1, 1);
      drive(1, 1, 0);
      drive(0, 0, 0);

      at_n = '{12, 4};
      ae_n = '{3, 1};
      repeat (17) drive(0, 1, 0);
      repeat (17) drive(0, 0, 1);
      drive(1, 0, 0);

      // Watermark: push 9, pop 9.
      repeat (9) drive(0, 1, 0);
      repeat (9) drive(0, 0, 1);
      repeat (2) drive(0, 0, 0);

      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            at_n[0] = $urandom_range(0, 17); ae_n[0] = $urandom_range(0, 17);
            at_n[1] = $urandom_range(0, 6);  ae_n[1] = $urandom_range(0, 6);
         end
         drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50);
      end

      // Asynchronous reset in the middle of a push burst.
      drive(1, 0, 0);
      repeat (3) drive(0, 1, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      cmp("async_rst.d16.count", int'(cnt16), 0);
      cmp("async_rst.d16.wr_ptr", int'(wr16), 0);
      cmp("async_rst.d16.wmark", int'(wm16), 0);
      cmp("async_rst.d16.empty", int'(empty16), 1);
      cmp("async_rst.d5.count", int'(cnt5), 0);
      model_clear();
      @(negedge clk);
      wen = 1'b0; oen = 1'b0; clr = 1'b0;
      rst_n = 1'b1;

      for (int i = 0; i < 200; i++)
         drive(1'b0, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45);

      @(posedge clk);
      #3;
      cmp("scoreboard_drained", q0.size() + q1.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
